// File: rtl/fp_normalizer.sv
// Normaliser ahead of the rounder: 12-bit two's-complement in, sign/exp/sig/round bit out.
// Iterative leading-one search (1..8 cycles), or a 1-cycle priority encoder when NORM_FAST_EN is defined.
module fp_normalizer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] d,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sign,
    output logic [2:0]  exp,
    output logic [3:0]  sig,
    output logic        fifth_bit
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_nxt;
    logic        sign_nxt;
    logic [2:0]  exp_nxt;
    logic [3:0]  sig_nxt;
    logic        fifth_nxt;
    logic [10:0] neg_mag;
    logic [10:0] mag;

    // -2048 has no positive 12-bit counterpart, so it clamps to the largest magnitude.
    always_comb begin
        neg_mag = ~d[10:0] + 11'd1;
        if (d[11] && (d[10:0] == 11'd0)) begin
            mag = 11'h7FF;
        end else if (d[11]) begin
            mag = neg_mag;
        end else begin
            mag = d[10:0];
        end
    end

`ifdef NORM_FAST_EN
    logic [10:0] fw;
    logic [2:0]  fe;

    always_comb begin
        fw = mag;
        fe = 3'd7;
        for (int i = 0; i < 7; i++) begin
            if (!fw[10] && (fe != 3'd0)) begin
                fw = fw << 1;
                fe = fe - 3'd1;
            end
        end
    end
`else
    logic [10:0] w, w_nxt;
    logic [2:0]  e, e_nxt;
`endif

    always_comb begin
        state_nxt = state;
        sign_nxt  = sign;
        exp_nxt   = exp;
        sig_nxt   = sig;
        fifth_nxt = fifth_bit;
`ifndef NORM_FAST_EN
        w_nxt     = w;
        e_nxt     = e;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_nxt  = d[11];
`ifdef NORM_FAST_EN
                    exp_nxt   = fe;
                    sig_nxt   = fw[10:7];
                    fifth_nxt = fw[6];
                    state_nxt = DONE;
`else
                    w_nxt     = mag;
                    e_nxt     = 3'd7;
                    state_nxt = SHIFT;
`endif
                end
            end
`ifndef NORM_FAST_EN
            SHIFT: begin
                // exp=0 is the denormal floor: w then holds magnitude[3:0] in its top nibble.
                if (w[10] || (e == 3'd0)) begin
                    exp_nxt   = e;
                    sig_nxt   = w[10:7];
                    fifth_nxt = w[6];
                    state_nxt = DONE;
                end else begin
                    w_nxt = w << 1;
                    e_nxt = e - 3'd1;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sign      <= 1'b0;
            exp       <= 3'd0;
            sig       <= 4'd0;
            fifth_bit <= 1'b0;
`ifndef NORM_FAST_EN
            w         <= 11'd0;
            e         <= 3'd0;
`endif
        end else begin
            state     <= state_nxt;
            sign      <= sign_nxt;
            exp       <= exp_nxt;
            sig       <= sig_nxt;
            fifth_bit <= fifth_nxt;
`ifndef NORM_FAST_EN
            w         <= w_nxt;
            e         <= e_nxt;
`endif
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed-vector bench for fp_normalizer; expected latency follows NORM_FAST_EN.
module tb_fp_normalizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] d;
    logic        out_valid;
    logic        out_ready;
    logic        sign;
    logic [2:0]  exp;
    logic [3:0]  sig;
    logic        fifth_bit;

    int n_tests = 0;
    int n_fail  = 0;

    fp_normalizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign      (sign),
        .exp       (exp),
        .sig       (sig),
        .fifth_bit (fifth_bit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] d;
        logic        s;
        logic [2:0]  x;
        logic [3:0]  m;
        logic        f;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic int exp_lat(input int l);
`ifdef NORM_FAST_EN
        return 1 + 0 * l;
`else
        return l;
`endif
    endfunction

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 20);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        d        = v.d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_busy"}, 32'(in_ready), 32'd0);
        wait_out(n);
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat(v.lat)));
        chk({tag, "_sign"}, 32'(sign), 32'(v.s));
        chk({tag, "_exp"}, 32'(exp), 32'(v.x));
        chk({tag, "_sig"}, 32'(sig), 32'(v.m));
        chk({tag, "_fifth"}, 32'(fifth_bit), 32'(v.f));
        if (out_ready) begin
            @(posedge clk); #1;
            chk({tag, "_drain"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        int  n;
        bit  stale;

        //            d        s     exp   sig     fifth lat
        vecs[0]  = '{12'h7FF, 1'b0, 3'd7, 4'hF, 1'b1, 1};
        vecs[1]  = '{12'h02C, 1'b0, 3'd2, 4'hB, 1'b0, 6};
        vecs[2]  = '{12'hFFF, 1'b1, 3'd0, 4'h1, 1'b0, 8};
        vecs[3]  = '{12'h000, 1'b0, 3'd0, 4'h0, 1'b0, 8};
        vecs[4]  = '{12'h800, 1'b1, 3'd7, 4'hF, 1'b1, 1};
        vecs[5]  = '{12'h001, 1'b0, 3'd0, 4'h1, 1'b0, 8};
        vecs[6]  = '{12'h400, 1'b0, 3'd7, 4'h8, 1'b0, 1};
        vecs[7]  = '{12'h0FF, 1'b0, 3'd4, 4'hF, 1'b1, 4};
        vecs[8]  = '{12'hF01, 1'b1, 3'd4, 4'hF, 1'b1, 4};
        vecs[9]  = '{12'h00F, 1'b0, 3'd0, 4'hF, 1'b0, 8};
        vecs[10] = '{12'h010, 1'b0, 3'd1, 4'h8, 1'b0, 7};
        vecs[11] = '{12'h801, 1'b1, 3'd7, 4'hF, 1'b1, 1};
        vecs[12] = '{12'h155, 1'b0, 3'd5, 4'hA, 1'b1, 3};

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        d         = 12'h000;
        out_ready = 1'b1;
        #3 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_outputs", {26'd0, sign, exp, sig, fifth_bit}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Output held under backpressure; a pending in_valid waits for the handshake.
        out_ready = 1'b0;
        run_vec(vecs[1], "hold");
        in_valid = 1'b1;
        d        = 12'h7FF;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("hold%0d_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("hold%0d_in_ready", c), 32'(in_ready), 32'd0);
            chk($sformatf("hold%0d_result", c), {24'd0, sign, exp, sig}, {24'd0, 1'b0, 3'd2, 4'hB});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_handshake_valid", 32'(out_valid), 32'd0);
        chk("hold_handshake_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("hold_next_accepted", 32'(in_ready), 32'd0);
        wait_out(n);
        chk("hold_next_latency", 32'(n), 32'd1);
        chk("hold_next_result", {23'd0, sign, exp, sig, fifth_bit}, {23'd0, 1'b0, 3'd7, 4'hF, 1'b1});
        @(posedge clk); #1;

        // Reset in flight discards the sample.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        d         = 12'h001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_outputs", {26'd0, sign, exp, sig, fifth_bit}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        stale     = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        chk("midrst_no_stale", 32'(stale), 32'd0);
        run_vec(vecs[12], "postrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
